// File: rtl/usb_test_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// usb_test_pkg : shared state encoding and handshake helper for the
//                USB packet test-path blocks.            Rev 1.0
// ------------------------------------------------------------------
package usb_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } burst_state_t;

    localparam logic c_BEAT_VALID = 1'b1;
    localparam logic c_BEAT_IDLE  = 1'b0;

    function automatic logic hs_accept(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_hist_shreg.sv
`default_nettype none
// ------------------------------------------------------------------
// usb_hist_shreg : history shift register, buff[0] = previous cycle.
//                                                         Rev 1.0
// ------------------------------------------------------------------
module usb_hist_shreg #(
    parameter int HIST_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d,
    output logic [HIST_W-1:0] buff
);

    generate
        if (HIST_W == 1) begin : g_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    buff <= '0;
                end else begin
                    buff <= d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    buff <= '0;
                end else begin
                    buff <= {buff[HIST_W-2:0], d};
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/usb_burst_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// usb_burst_gen : valid/ready burst generator with gaps, stall
//                 timeout, abort and tx_valid history.    Rev 1.0
// ------------------------------------------------------------------
module usb_burst_gen #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 10,
    parameter int CNT_W     = 10,
    parameter int GAP       = 0,
    parameter int TIMEOUT   = 16,
    parameter int SEED      = 0,
    parameter int HIST_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_data,
    input  logic              abort,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [HIST_W-1:0] buff
);

    import usb_test_pkg::*;

    localparam int STALL_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   c_BURST_LAST = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]   c_GAP_LAST   = CNT_W'(GAP - 1);
    localparam logic [STALL_W-1:0] c_STALL_LAST = STALL_W'(TIMEOUT);
    localparam logic [DATA_W-1:0]  c_SEED       = DATA_W'(SEED);

    generate
        if (BURST_LEN < 1) begin : g_chk_burst_min
            $error("usb_burst_gen: BURST_LEN must be >= 1");
        end
        if (BURST_LEN >= (1 << CNT_W)) begin : g_chk_burst_max
            $error("usb_burst_gen: BURST_LEN must be < 2**CNT_W");
        end
        if (TIMEOUT < 1) begin : g_chk_timeout
            $error("usb_burst_gen: TIMEOUT must be >= 1");
        end
        if (GAP >= (1 << CNT_W)) begin : g_chk_gap
            $error("usb_burst_gen: GAP must be < 2**CNT_W");
        end
    endgenerate

    burst_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic [CNT_W-1:0]    r_gap_cnt, w_gap_cnt_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [STALL_W-1:0]  r_stall_cnt, w_stall_cnt_nxt;
    logic                r_timeout_err, w_timeout_err_nxt;
    logic                w_handshake;
    logic [CNT_W-1:0]    w_beat_inc;
    logic [STALL_W-1:0]  w_stall_inc;

    assign tx_valid    = (r_state == ST_SEND) ? c_BEAT_VALID : c_BEAT_IDLE;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign timeout_err = r_timeout_err;
    assign tx_data     = r_data;
    assign beat_cnt    = r_beat_cnt;

    assign w_handshake = hs_accept(tx_valid, tx_ready);
    assign w_beat_inc  = r_beat_cnt + CNT_W'(1);
    assign w_stall_inc = r_stall_cnt + STALL_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_beat_cnt_nxt    = r_beat_cnt;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_data_nxt        = r_data;
        w_stall_cnt_nxt   = r_stall_cnt;
        w_timeout_err_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (send_data) begin
                    w_state_nxt     = ST_SEND;
                    w_beat_cnt_nxt  = '0;
                    w_stall_cnt_nxt = '0;
                    w_data_nxt      = c_SEED;
                end
            end
            ST_SEND: begin
                if (w_handshake) begin
                    w_beat_cnt_nxt  = w_beat_inc;
                    w_data_nxt      = r_data + DATA_W'(1);
                    w_stall_cnt_nxt = '0;
                    if (w_beat_inc == c_BURST_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else if (GAP > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = '0;
                    end
                end else begin
                    w_stall_cnt_nxt = w_stall_inc;
                    if (w_stall_inc == c_STALL_LAST) begin
                        w_state_nxt       = ST_IDLE;
                        w_timeout_err_nxt = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides the state move but keeps any same-cycle beat count.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt       = ST_IDLE;
            w_timeout_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_beat_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_data        <= c_SEED;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_data        <= w_data_nxt;
            r_stall_cnt   <= w_stall_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    usb_hist_shreg #(
        .HIST_W (HIST_W)
    ) u_hist (
        .clk   (clk),
        .reset (reset),
        .d     (tx_valid),
        .buff  (buff)
    );

endmodule
`default_nettype wire
